// File: rtl/onehot_mux_pkg.sv
// onehot_mux_pkg: shared select encodings and defaults for onehot_mux_2
package onehot_mux_pkg;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_D0   = 2'b01;
    localparam logic [1:0] SEL_D1   = 2'b10;

    localparam int ERR_CNT_W_DEF = 8;

endpackage

// File: rtl/onehot_mux_2_check.sv
// onehot_check: 2-bit one-hot detector
// Ports: s (2-bit select in), sel_ok (1 when s is exactly one-hot)
module onehot_check (
    input  logic [1:0] s,
    output logic       sel_ok
);

    assign sel_ok = s[0] ^ s[1];

endmodule

// File: rtl/onehot_mux_2.sv
// onehot_mux_2: AND-OR two-input mux with one-hot select, registered copy and select monitor
// Ports: clk, rst (sync active-high), d0/d1 (data), s (one-hot select),
//        y (comb result), y_q (registered y), sel_ok (comb legality),
//        sel_err (sticky illegal flag), err_cnt (saturating illegal count).
// Macro ONEHOT_MUX_2_ERR_EN compiles in sel_err/err_cnt; otherwise they are tied to 0.
module onehot_mux_2
    import onehot_mux_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     d0,
    input  logic [WIDTH-1:0]     d1,
    input  logic [1:0]           s,
    output logic [WIDTH-1:0]     y,
    output logic [WIDTH-1:0]     y_q,
    output logic                 sel_ok,
    output logic                 sel_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // AND-OR keeps illegal selects defined: 00 gives 0, 11 gives d0|d1
    assign y = ({WIDTH{s[0]}} & d0) | ({WIDTH{s[1]}} & d1);

    onehot_check u_check (
        .s      (s),
        .sel_ok (sel_ok)
    );

    always_ff @(posedge clk) begin
        y_q <= rst ? '0 : y;
    end

`ifdef ONEHOT_MUX_2_ERR_EN
    logic                 sel_err_q, sel_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        sel_err_d = sel_err_q | ~sel_ok;
        err_cnt_d = (!sel_ok && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        sel_err_q <= rst ? 1'b0 : sel_err_d;
        err_cnt_q <= rst ? '0 : err_cnt_d;
    end

    assign sel_err = sel_err_q;
    assign err_cnt = err_cnt_q;
`else
    assign sel_err = 1'b0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_onehot_mux_2.sv
// tb_onehot_mux_2: directed plus randomized checks of onehot_mux_2 against a behavioural model
module tb_onehot_mux_2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d0, d1, y, y_q;
    logic [1:0]  s;
    logic        sel_ok, sel_err;
    logic [7:0]  err_cnt;

`ifdef ONEHOT_MUX_2_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int passed = 0;
    int total  = 0;

    // behavioural reference state
    logic [31:0] m_yq;
    bit          m_err;
    int          m_cnt;

    always #5 clk = ~clk;

    onehot_mux_2 #(.WIDTH(32), .ERR_CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .d0      (d0),
        .d1      (d1),
        .s       (s),
        .y       (y),
        .y_q     (y_q),
        .sel_ok  (sel_ok),
        .sel_err (sel_err),
        .err_cnt (err_cnt)
    );

    function automatic logic [31:0] ref_y(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel);
        case (sel)
            2'd1:    return a;
            2'd2:    return b;
            2'd3:    return a | b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                        input logic r, input string tag);
        logic [31:0] ey;
        bit          legal;
        d0 = a; d1 = b; s = sel; rst = r;
        #1;
        ey    = ref_y(a, b, sel);
        legal = (sel == 2'd1) || (sel == 2'd2);
        chk({tag, ".y"}, y, ey);
        chk({tag, ".sel_ok"}, {31'd0, sel_ok}, {31'd0, legal});
        @(posedge clk);
        if (r) begin
            m_yq = 32'd0; m_err = 1'b0; m_cnt = 0;
        end else begin
            m_yq = ey;
            if (!legal && ERR_EN) begin
                m_err = 1'b1;
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
        end
        @(negedge clk);
        chk({tag, ".y_q"}, y_q, m_yq);
        chk({tag, ".sel_err"}, {31'd0, sel_err}, {31'd0, m_err});
        chk({tag, ".err_cnt"}, {24'd0, err_cnt}, m_cnt[31:0]);
    endtask

    initial begin
        m_yq = 32'd0; m_err = 1'b0; m_cnt = 0;
        step(32'hDEADBEEF, 32'h0, 2'b00, 1'b1, "reset");
        step(32'h000000FF, 32'h0, 2'b01, 1'b0, "sel_d0");
        step(32'h0, 32'h0000FF00, 2'b10, 1'b0, "sel_d1");
        step(32'hFFFFFFFF, 32'h12345678, 2'b00, 1'b0, "sel_none");
        step(32'h0000000F, 32'hF0000000, 2'b11, 1'b0, "sel_both");
        step(32'h0000000F, 32'hF0000000, 2'b11, 1'b0, "sel_both2");
        step(32'hA5A5A5A5, 32'h5A5A5A5A, 2'b01, 1'b1, "rst_mid");
        for (int i = 0; i < 60; i++)
            step($urandom, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0, "rand");
        for (int i = 0; i < 300; i++)
            step($urandom, $urandom, 2'b00, 1'b0, "sat");
        step(32'h11111111, 32'h22222222, 2'b10, 1'b0, "sat_hold");
        step(32'h11111111, 32'h22222222, 2'b11, 1'b1, "rst_illegal");
        step(32'h33333333, 32'h44444444, 2'b01, 1'b0, "post_rst");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/onehot_mux_2.md
# onehot_mux_2

Parameterised two-input multiplexer steered by a one-hot select, used wherever the core picks between two equal-width operands or tags (bypass selection, result steering). The data path is purely combinational. A registered copy of the output and optional select-legality monitoring sit alongside it on the single core clock.

## Interface
- WIDTH, default 32: bit width of d0, d1, y, y_q.
- ERR_CNT_W, default 8: width of the illegal-select counter.

- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- d0  input  WIDTH  data input, selected by s[0].
- d1  input  WIDTH  data input, selected by s[1].
- s  input  2  one-hot select: 2'b01 → d0, 2'b10 → d1.
- y  output  WIDTH  combinational mux result.
- y_q  output  WIDTH  y registered one cycle.
- sel_ok  output  1  combinational; 1 when s is exactly one-hot.
- sel_err  output  1  sticky registered flag; set on any illegal select.
- err_cnt  output  ERR_CNT_W  saturating count of cycles with illegal select.

## Operation
- y = ({WIDTH{s[0]}} & d0) | ({WIDTH{s[1]}} & d1). AND-OR form only; no priority logic.
- Illegal selects:
  - s=2'b00 → y=0.
  - s=2'b11 → y=d0|d1.
  - Both results are defined and required, not X.
- sel_ok = s[0]^s[1].
- y_q captures y every cycle.
- sel_err:
  - Set when sel_ok=0 at a rising edge.
  - Held until reset.
- err_cnt:
  - Increments by 1 per edge with sel_ok=0.
  - Saturates at all-ones; no wrap.
- Reset values: y_q=0, sel_err=0, err_cnt=0. y and sel_ok are not affected by reset.

## Timing
- y and sel_ok: zero-cycle latency, combinational from d0/d1/s. Valid within the same delta/settle window.
- y_q, sel_err, err_cnt: one-cycle latency. The value registered at edge N reflects inputs sampled at edge N.
- Reset has priority over all updates. If rst=1 and an illegal select occur on the same edge, the flags are 0 after the edge.
- Reset asserted mid-stream: y_q clears on the next edge while y continues to follow the inputs.
- Saturated err_cnt stays at all-ones until reset.

## Configuration
- Macro ONEHOT_MUX_2_ERR_EN.
- Defined: sel_err and err_cnt logic is compiled in as described above.
- Undefined:
  - sel_err and err_cnt are tied to 0 and contain no flops.
  - sel_ok, y and y_q are unchanged.

## Structure
- Shared package onehot_mux_pkg holds:
  - Select encodings SEL_D0=2'b01, SEL_D1=2'b10, SEL_NONE=2'b00.
  - Default ERR_CNT_W.
- One sub-module, onehot_check: a 2-bit one-hot detector producing sel_ok, instantiated once.

## Test plan
- d1=0, d0=32'h000000FF, s=2'b01 → y=32'h000000FF, sel_ok=1. y_q=32'h000000FF after next edge.
- d1=32'h0000FF00, d0=0, s=2'b10 → y=32'h0000FF00, sel_ok=1, sel_err stays 0.
- s=2'b00, d0=32'hFFFFFFFF, d1=32'h12345678 → y=0, sel_ok=0. After edge: sel_err=1, err_cnt=1.
- s=2'b11, d0=32'h0000000F, d1=32'hF0000000 → y=32'hF000000F; err_cnt increments each edge.
- Hold s=2'b00 for 300 edges → err_cnt=8'hFF, no wrap. Assert rst for one edge → y_q=0, sel_err=0, err_cnt=0.
- Build without ONEHOT_MUX_2_ERR_EN, apply s=2'b00 → sel_err=0, err_cnt=0; y=0.
